// File: rtl/regfile_pkg.sv
// Shared register-file constants and the response record carried by the
// read front-end and its response queue.
package regfile_pkg;

  localparam int RF_ADDR_W = 8;
  localparam int RF_DATA_W = 64;
  localparam int RF_RD_LAT = 3;
  localparam int RF_TAG_W  = 4;

  typedef struct packed {
    logic [RF_DATA_W-1:0] data;
    logic [RF_TAG_W-1:0]  tag;
  } rf_rsp_t;

endpackage

// File: rtl/regfile_rsp_fifo.sv
// Response queue: DEPTH-entry FIFO with modulo-DEPTH pointers, legal
// push+pop at any occupancy, occupancy count exported for credit tracking.
module regfile_rsp_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  rf_rsp_t          push_item,
  input  logic             pop,
  output logic             out_valid,
  output rf_rsp_t          out_item,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  rf_rsp_t          mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : p + PTR_W'(1);
  endfunction

  assign pop_s = pop & (count_r != CNT_W'(0));

  // Occupancy update from the push/pop pair.
  always_comb begin
    count_nxt_s = count_r;
    case ({push, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage, pointers and count.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_item;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_nxt_s;
    end
  end

  assign out_valid = (count_r != CNT_W'(0));
  assign out_item  = mem_r[rd_ptr_r];
  assign count     = count_r;

endmodule

// File: rtl/regfile_256_rd_ctrl.sv
// Read front-end for the 256x64 1W1R register file: tagged requests, a
// 3-stage tracking pipe with late-write bypass, and a credit-guarded FIFO.
module regfile_256_rd_ctrl
  import regfile_pkg::*;
#(
  parameter int TAG_W = RF_TAG_W,
  parameter int DEPTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [RF_ADDR_W-1:0] req_addr,
  input  logic [TAG_W-1:0]     req_tag,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [RF_DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]     rsp_tag,
  input  logic                 wr_valid,
  input  logic [RF_ADDR_W-1:0] wr_addr,
  input  logic [RF_DATA_W-1:0] wr_data,
  output logic [RF_ADDR_W-1:0] rf_raddr0,
  output logic                 rf_wena,
  output logic [RF_ADDR_W-1:0] rf_waddr,
  output logic [RF_DATA_W-1:0] rf_wdata,
  input  logic [RF_DATA_W-1:0] rf_rdata0
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OUT_W = $clog2(DEPTH + 4);

  logic                 accept_s;
  logic                 req_ready_s;
  logic                 bypass_hit_s;
  logic [OUT_W-1:0]     outstanding_s;
  logic                 fifo_valid_s;
  logic [CNT_W-1:0]     fifo_count_s;
  rf_rsp_t              push_rsp_s;
  rf_rsp_t              head_rsp_s;

  logic                 s1_valid_r, s2_valid_r, s3_valid_r;
  logic [RF_ADDR_W-1:0] s1_addr_r, s2_addr_r;
  logic [TAG_W-1:0]     s1_tag_r, s2_tag_r, s3_tag_r;
  logic                 s3_hit_r;
  logic [RF_DATA_W-1:0] s3_byp_r;

  // Credits cover every read between issue and pop, so a push never meets a full FIFO.
  assign outstanding_s = OUT_W'(s1_valid_r) + OUT_W'(s2_valid_r) + OUT_W'(s3_valid_r)
                       + OUT_W'(fifo_count_s);
  assign req_ready_s   = (outstanding_s < OUT_W'(DEPTH)) & ~reset;
  assign accept_s      = req_valid & req_ready_s;
  assign req_ready     = req_ready_s;

  assign rf_raddr0 = req_addr;
  assign rf_wena   = wr_valid & ~reset;
  assign rf_waddr  = wr_addr;
  assign rf_wdata  = wr_data;

  // The array misses only a write landing while the read sits in stage 2.
  assign bypass_hit_s = s2_valid_r & wr_valid & (wr_addr == s2_addr_r);

  // Request tracking pipe aligned with the array read latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
      s3_valid_r <= 1'b0;
      s1_addr_r  <= '0;
      s2_addr_r  <= '0;
      s1_tag_r   <= '0;
      s2_tag_r   <= '0;
      s3_tag_r   <= '0;
      s3_hit_r   <= 1'b0;
      s3_byp_r   <= '0;
    end else begin
      s1_valid_r <= accept_s;
      s1_addr_r  <= req_addr;
      s1_tag_r   <= req_tag;
      s2_valid_r <= s1_valid_r;
      s2_addr_r  <= s1_addr_r;
      s2_tag_r   <= s1_tag_r;
      s3_valid_r <= s2_valid_r;
      s3_tag_r   <= s2_tag_r;
      s3_hit_r   <= bypass_hit_s;
      s3_byp_r   <= wr_data;
    end
  end

  // Response record entering the FIFO from stage 3.
  always_comb begin
    push_rsp_s      = '0;
    push_rsp_s.data = s3_hit_r ? s3_byp_r : rf_rdata0;
    push_rsp_s.tag  = RF_TAG_W'(s3_tag_r);
  end

  regfile_rsp_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_rsp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (s3_valid_r),
    .push_item (push_rsp_s),
    .pop       (rsp_ready),
    .out_valid (fifo_valid_s),
    .out_item  (head_rsp_s),
    .count     (fifo_count_s)
  );

  assign rsp_valid = fifo_valid_s;
  assign rsp_data  = head_rsp_s.data;
  assign rsp_tag   = TAG_W'(head_rsp_s.tag);

endmodule

// File: tb/tb_regfile_256_rd_ctrl.sv
// Bench for regfile_256_rd_ctrl: behavioural register file, transaction-level
// scoreboard (array shadow + expected-response queue + credit count).
module tb_regfile_256_rd_ctrl;

  localparam int DEPTH = 8;
  localparam int TAG_W = 4;

  logic        clock = 1'b0;
  logic        reset, req_valid, req_ready, rsp_valid, rsp_ready, wr_valid, rf_wena;
  logic [7:0]  req_addr, wr_addr, rf_raddr0, rf_waddr;
  logic [3:0]  req_tag, rsp_tag;
  logic [63:0] rsp_data, wr_data, rf_wdata, rf_rdata0;

  always #5 clock = ~clock;

  regfile_256_rd_ctrl #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .rf_raddr0(rf_raddr0), .rf_wena(rf_wena), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_rdata0(rf_rdata0)
  );

  // Register file: address at c returns data at c+3 including writes up to c+1.
  logic [63:0] rf_mem [256];
  logic [7:0]  rf_a1;
  logic [63:0] rf_d2, rf_d3;
  always @(posedge clock) begin
    if (rf_wena) rf_mem[rf_waddr] <= rf_wdata;
    rf_a1 <= rf_raddr0;
    rf_d2 <= (rf_wena && rf_waddr == rf_a1) ? rf_wdata : rf_mem[rf_a1];
    rf_d3 <= rf_d2;
  end
  assign rf_rdata0 = rf_d3;

  typedef struct { logic [7:0] addr; logic [3:0] tag; int cyc; } pend_t;
  typedef struct { logic [63:0] data; logic [3:0] tag; int rdy; } exp_t;

  pend_t       pend_q[$];
  exp_t        exp_q[$];
  logic [63:0] shadow [256];
  int          cnt, cyc, n_cmp, n_fail, n_pops, acc_cyc, pop_cyc;
  bit          chk_en, last_acc, last_pop;
  logic [63:0] last_data;
  logic [3:0]  last_tag;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive, compare against the model, then advance the model.
  task automatic step(input logic rv, input logic [7:0] ra, input logic [3:0] rt,
                      input logic wv, input logic [7:0] wa, input logic [63:0] wd,
                      input logic rr, input logic rst);
    bit    exp_v, exp_rdy;
    pend_t p;
    exp_t  e;
    @(negedge clock);
    reset = rst; req_valid = rv; req_addr = ra; req_tag = rt;
    wr_valid = wv; wr_addr = wa; wr_data = wd; rsp_ready = rr;
    #1;
    exp_v   = (exp_q.size() > 0) && (exp_q[0].rdy <= cyc);
    exp_rdy = !rst && (cnt < DEPTH);
    if (chk_en) begin
      check_eq("req_ready", req_ready, exp_rdy);
      check_eq("rsp_valid", rsp_valid, exp_v);
      check_eq("rf_wena", rf_wena, wv && !rst);
      if (exp_v) begin
        check_eq("rsp_data", rsp_data, exp_q[0].data);
        check_eq("rsp_tag", rsp_tag, exp_q[0].tag);
      end
    end
    last_acc = rv && (req_ready === 1'b1) && !rst;
    last_pop = exp_v && rr && !rst;
    if (last_acc) acc_cyc = cyc;
    if (last_pop) begin
      last_data = rsp_data;
      last_tag  = rsp_tag;
      pop_cyc   = cyc;
      n_pops++;
    end
    @(posedge clock);
    if (rst) begin
      pend_q.delete();
      exp_q.delete();
      cnt = 0;
    end else begin
      if (last_pop) begin exp_q.delete(0); cnt--; end
      if (last_acc) begin p.addr = ra; p.tag = rt; p.cyc = cyc; pend_q.push_back(p); cnt++; end
      if (wv) shadow[wa] = wd;
      // Response value is fixed once the writes of cycle c+2 are known.
      while (pend_q.size() > 0 && pend_q[0].cyc + 2 == cyc) begin
        e.data = shadow[pend_q[0].addr]; e.tag = pend_q[0].tag; e.rdy = pend_q[0].cyc + 4;
        exp_q.push_back(e);
        pend_q.delete(0);
      end
    end
    cyc++;
    chk_en = 1'b1;
  endtask

  task automatic idle(input int n, input logic rr);
    repeat (n) step(1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 64'h0, rr, 1'b0);
  endtask
  task automatic wr(input logic [7:0] a, input logic [63:0] d);
    step(1'b0, 8'h00, 4'h0, 1'b1, a, d, 1'b1, 1'b0);
  endtask
  task automatic rd(input logic [7:0] a, input logic [3:0] t, input logic rr);
    step(1'b1, a, t, 1'b0, 8'h00, 64'h0, rr, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, drops, p0, k, pct;
    int pcts [4] = '{100, 90, 50, 10};
    n_cmp = 0; n_fail = 0; cnt = 0; cyc = 0; n_pops = 0; chk_en = 1'b0;
    reset = 1'b1; req_valid = 1'b0; req_addr = 8'h00; req_tag = 4'h0;
    wr_valid = 1'b0; wr_addr = 8'h00; wr_data = 64'h0; rsp_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin rf_mem[i] = 64'h0; shadow[i] = 64'h0; end
    rf_a1 = 8'h00; rf_d2 = 64'h0; rf_d3 = 64'h0;

    repeat (2) step(1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 64'h0, 1'b1, 1'b1);
    #2;
    check_eq("rst_rsp_valid", rsp_valid, 64'h0);
    check_eq("rst_rsp_data", rsp_data, 64'h0);
    check_eq("rst_rsp_tag", rsp_tag, 64'h0);

    // Single read and latency
    wr(8'd5, 64'h1111); idle(3, 1'b1);
    rd(8'd5, 4'd3, 1'b1); idle(6, 1'b1);
    check_eq("single_lat", pop_cyc - acc_cyc, 64'd4);
    check_eq("single_data", last_data, 64'h1111);
    check_eq("single_tag", last_tag, 64'd3);

    // Bypass windows: write in c+2, c+3, c+1
    wr(8'd9, 64'hA); idle(3, 1'b1); rd(8'd9, 4'd1, 1'b1); idle(1, 1'b1); wr(8'd9, 64'hB); idle(6, 1'b1);
    check_eq("byp_c2", last_data, 64'hB);
    wr(8'd9, 64'hA); idle(3, 1'b1); rd(8'd9, 4'd2, 1'b1); idle(2, 1'b1); wr(8'd9, 64'hB); idle(6, 1'b1);
    check_eq("byp_c3", last_data, 64'hA);
    wr(8'd9, 64'hA); idle(3, 1'b1); rd(8'd9, 4'd4, 1'b1); wr(8'd9, 64'hB); idle(6, 1'b1);
    check_eq("byp_c1", last_data, 64'hB);

    // Streaming
    for (int i = 0; i < 64; i++) wr(8'(i), 64'(i));
    idle(3, 1'b1);
    drops = 0; p0 = n_pops;
    for (int i = 0; i < 64; i++) begin
      rd(8'(i), 4'(i % 16), 1'b1);
      if (!last_acc) drops++;
    end
    idle(8, 1'b1);
    check_eq("stream_drops", drops, 64'd0);
    check_eq("stream_pops", n_pops - p0, 64'd64);
    check_eq("stream_last", last_data, 64'd63);

    // Backpressure
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      rd(8'(100 + i), 4'(i), 1'b0);
      if (last_acc) acc++;
    end
    check_eq("bp_accept", acc, 64'd8);
    p0 = n_pops; k = 0;
    do begin idle(1, 1'b1); k++; end while (n_pops == p0 && k < 5);
    #2;
    check_eq("bp_ready_rise", req_ready, 64'd1);
    idle(12, 1'b1);
    check_eq("bp_drain", n_pops - p0, 64'd8);

    // Random traffic across rsp_ready biases
    for (int s = 0; s < 4; s++) begin
      pct = pcts[s]; acc = 0; k = 0;
      while (acc < 250 && k < 5000) begin
        step($urandom_range(99) < 80, 8'($urandom_range(15)), 4'($urandom),
             $urandom_range(99) < 30, 8'($urandom_range(15)), {$urandom, $urandom},
             $urandom_range(99) < pct, 1'b0);
        if (last_acc) acc++;
        k++;
      end
      check_eq("rand_accepts", acc, 64'd250);
    end
    idle(40, 1'b1);
    check_eq("rand_drained", exp_q.size() + pend_q.size(), 64'd0);

    // Reset with 4 queued and 3 in flight
    for (int i = 0; i < 4; i++) rd(8'(20 + i), 4'(i), 1'b0);
    idle(4, 1'b0);
    for (int i = 0; i < 3; i++) rd(8'(24 + i), 4'(i), 1'b0);
    step(1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 64'h0, 1'b0, 1'b1);
    #2;
    check_eq("rst_mid_valid", rsp_valid, 64'd0);
    p0 = n_pops;
    idle(10, 1'b1);
    check_eq("rst_no_stale", n_pops - p0, 64'd0);
    rd(8'd5, 4'd6, 1'b1); idle(6, 1'b1);
    check_eq("rst_after_pops", n_pops - p0, 64'd1);
    check_eq("rst_after_data", last_data, shadow[5]);
    check_eq("rst_after_tag", last_tag, 64'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
